// File: rtl/softmax_in_unpack.sv
// softmax_in_unpack
//   Unpacks TOUT-lane packed words into one DW-bit element per cycle for the
//   softmax core. The last word of each row carries ((CH_in-1)%TOUT)+1 valid
//   lanes. The zero-padded lanes above that count are skipped and never
//   emitted. Throughput is one element per cycle, with no bubble between words.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   CH_in_div_Tout  words per row (ceil(CH_in/TOUT)), >= 1
//   CH_in           elements per row, >= 1
//   dat_in_vld/rdy  packed word handshake; dat_in lane i = dat_in[i*DW+:DW]
//   dat_out_vld/rdy element handshake; dat_out is 0 while dat_out_vld=0
//   dat_out_last    element is last of its row (qualified by dat_out_vld)
//   busy            a word is held or a row is partially consumed
//   pad_err         (only with SOFTMAX_UNPACK_PAD_CHK_EN) sticky flag, set
//                   when a padded lane of a row's last word is nonzero
//
// Configuration macro: SOFTMAX_UNPACK_PAD_CHK_EN
module softmax_in_unpack #(
  parameter int unsigned TOUT      = 8,
  parameter int unsigned LOG2_TOUT = 3,
  parameter int unsigned DW        = 16,
  parameter int unsigned LOG2_CH   = 10,
  parameter int unsigned LOG2_PIX  = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [LOG2_CH-LOG2_TOUT-1:0] CH_in_div_Tout,
  input  logic [LOG2_PIX-1:0]          CH_in,
  input  logic                         dat_in_vld,
  output logic                         dat_in_rdy,
  input  logic [TOUT*DW-1:0]           dat_in,
  output logic                         dat_out_vld,
  input  logic                         dat_out_rdy,
  output logic [DW-1:0]                dat_out,
  output logic                         dat_out_last,
  output logic                         busy
`ifdef SOFTMAX_UNPACK_PAD_CHK_EN
  ,
  output logic                         pad_err
`endif
);

  localparam int unsigned WW = LOG2_CH - LOG2_TOUT;

  logic [TOUT*DW-1:0]   hold;
  logic                 full;
  logic [LOG2_TOUT-1:0] rd_cnt;
  logic [WW-1:0]        wd_cnt;

  logic [WW-1:0]        div_m1;
  logic [LOG2_PIX-1:0]  ch_m1;
  logic [LOG2_TOUT-1:0] lanes_m1;
  logic                 last_word;
  logic                 lane_last;
  logic                 in_fire;
  logic                 out_fire;

  assign div_m1    = CH_in_div_Tout - WW'(1);
  assign ch_m1     = CH_in - LOG2_PIX'(1);
  assign last_word = (wd_cnt == div_m1);
  // Last word of a row stops at the lane holding element CH_in-1.
  assign lanes_m1  = last_word ? ch_m1[LOG2_TOUT-1:0] : LOG2_TOUT'(TOUT - 1);
  assign lane_last = (rd_cnt == lanes_m1);

  assign out_fire  = full & dat_out_rdy;
  // A word can be accepted in the same cycle the held word's final lane
  // leaves, giving a gap-free handover; this path is combinational from
  // dat_out_rdy on purpose.
  assign dat_in_rdy = ~full | (out_fire & lane_last);
  assign in_fire    = dat_in_vld & dat_in_rdy;

  assign dat_out_vld  = full;
  assign dat_out_last = full & lane_last & last_word;
  assign busy         = full | (wd_cnt != '0);

  always_comb begin
    dat_out = '0;
    for (int unsigned i = 0; i < TOUT; i++) begin
      if (full && rd_cnt == LOG2_TOUT'(i)) dat_out = hold[i*DW +: DW];
    end
  end

  // Data holding register carries no reset; full gates its visibility.
  always_ff @(posedge clk) begin
    if (in_fire) hold <= dat_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full   <= 1'b0;
      rd_cnt <= '0;
      wd_cnt <= '0;
    end else begin
      if (out_fire) begin
        if (lane_last) begin
          rd_cnt <= '0;
          wd_cnt <= last_word ? '0 : wd_cnt + WW'(1);
        end else begin
          rd_cnt <= rd_cnt + LOG2_TOUT'(1);
        end
      end
      if (in_fire)                    full <= 1'b1;
      else if (out_fire && lane_last) full <= 1'b0;
    end
  end

`ifdef SOFTMAX_UNPACK_PAD_CHK_EN
  logic pad_hit;

  always_comb begin
    pad_hit = 1'b0;
    for (int unsigned i = 0; i < TOUT; i++) begin
      if (LOG2_TOUT'(i) > lanes_m1 && hold[i*DW +: DW] != '0) pad_hit = 1'b1;
    end
  end

  // Padding is inspected once per row, when lane 0 of the last word leaves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pad_err <= 1'b0;
    end else if (out_fire && rd_cnt == '0 && last_word && pad_hit) begin
      pad_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_softmax_in_unpack.sv
module tb_softmax_in_unpack;
  localparam int TOUT = 8;
  localparam int LOG2_TOUT = 3;
  localparam int DW = 16;
  localparam int LOG2_CH = 10;
  localparam int LOG2_PIX = 10;

  logic                         clk = 1'b0;
  logic                         rst;
  logic [LOG2_CH-LOG2_TOUT-1:0] CH_in_div_Tout;
  logic [LOG2_PIX-1:0]          CH_in;
  logic                         dat_in_vld;
  logic                         dat_in_rdy;
  logic [TOUT*DW-1:0]           dat_in;
  logic                         dat_out_vld;
  logic                         dat_out_rdy;
  logic [DW-1:0]                dat_out;
  logic                         dat_out_last;
  logic                         busy;
`ifdef SOFTMAX_UNPACK_PAD_CHK_EN
  logic                         pad_err;
`endif

  softmax_in_unpack #(
    .TOUT(TOUT), .LOG2_TOUT(LOG2_TOUT), .DW(DW), .LOG2_CH(LOG2_CH), .LOG2_PIX(LOG2_PIX)
  ) dut (
    .clk(clk), .rst(rst), .CH_in_div_Tout(CH_in_div_Tout), .CH_in(CH_in),
    .dat_in_vld(dat_in_vld), .dat_in_rdy(dat_in_rdy), .dat_in(dat_in),
    .dat_out_vld(dat_out_vld), .dat_out_rdy(dat_out_rdy), .dat_out(dat_out),
    .dat_out_last(dat_out_last), .busy(busy)
`ifdef SOFTMAX_UNPACK_PAD_CHK_EN
    , .pad_err(pad_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] dat;
    logic          last;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int failures = 0;
  int pops = 0;
  int cyc = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  bit rdy_log[64];
  int rdy_mode = 0;
  bit pad_arm = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Downstream ready generator: 0 = always ready, 1 = toggle, 2 = random.
  initial begin
    dat_out_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       dat_out_rdy = 1'b1;
        1:       dat_out_rdy = ~dat_out_rdy;
        default: dat_out_rdy = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: every accepted element is popped from the scoreboard and compared.
  bit            stall_prev = 0;
  logic [DW-1:0] prev_dat;
  bit            pad_next = 0;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      stall_prev = 0;
      pad_next = 0;
    end else begin
`ifdef SOFTMAX_UNPACK_PAD_CHK_EN
      if (pad_next) begin
        chk("pad_err_set", pad_err, 1);
        pad_next = 0;
      end
`endif
      if (stall_prev) begin
        chk("stall_vld", dat_out_vld, 1);
        chk("stall_dat", dat_out, prev_dat);
      end
      if (!dat_out_vld) chk("idle_dat_zero", dat_out, 0);
      if (dat_out_vld && dat_out_rdy) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out got=%0h exp=none", dat_out);
        end else begin
          e = sb_q.pop_front();
          chk("data", dat_out, e.dat);
          chk("last", dat_out_last, e.last);
        end
`ifdef SOFTMAX_UNPACK_PAD_CHK_EN
        if (pad_arm && pops == 16) begin
          chk("pad_err_before", pad_err, 0);
          pad_next = 1;
        end
`endif
        if (pops == 0) first_cyc = cyc;
        last_cyc = cyc;
        if (pops < 64) rdy_log[pops] = dat_in_rdy;
        pops++;
      end
      stall_prev = dat_out_vld & ~dat_out_rdy;
      prev_dat = dat_out;
    end
  end

  task automatic send_word(input logic [TOUT*DW-1:0] w);
    int  t;
    bit  got;
    t = 0;
    dat_in = w;
    dat_in_vld = 1'b1;
    forever begin
      @(negedge clk);
      got = dat_in_rdy;
      @(posedge clk);
      if (got) break;
      t++;
      if (t > 2000) begin
        checks++;
        failures++;
        $display("FAIL in_accept_timeout got=stalled exp=accepted");
        break;
      end
    end
    #1;
    dat_in_vld = 1'b0;
    dat_in = '0;
  endtask

  // Reference model: element k of a row is lane k%TOUT of word k/TOUT;
  // lanes at k >= ch are padding and produce nothing.
  task automatic send_row(input int ch, input int div, input bit seq, input bit pad_inj,
                          input int gap_max);
    logic [TOUT*DW-1:0] w;
    logic [DW-1:0]      v;
    exp_t               e;
    int                 k;
    for (int wi = 0; wi < div; wi++) begin
      w = '0;
      for (int l = 0; l < TOUT; l++) begin
        k = wi * TOUT + l;
        if (k < ch) begin
          v = seq ? DW'(k) : DW'($urandom);
          e.dat = v;
          e.last = (k == ch - 1);
          sb_q.push_back(e);
        end else begin
`ifdef SOFTMAX_UNPACK_PAD_CHK_EN
          v = (pad_inj && l == 6) ? DW'(1) : '0;
`else
          v = pad_inj ? DW'(1) : (DW'($urandom) | DW'(1));
`endif
        end
        w[l*DW +: DW] = v;
      end
      repeat ($urandom_range(0, gap_max)) begin
        @(posedge clk);
        #1;
      end
      send_word(w);
    end
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      if (sb_q.size() == 0 && !busy) break;
      t++;
      if (t > 4000) begin
        checks++;
        failures++;
        $display("FAIL %s_drain_timeout got=%0d_pending exp=0", name, sb_q.size());
        break;
      end
    end
    chk({name, "_busy_idle"}, busy, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int ch, input int div);
    CH_in = LOG2_PIX'(ch);
    CH_in_div_Tout = (LOG2_CH-LOG2_TOUT)'(div);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int ch, div, rows;
    rst = 1'b1;
    dat_in_vld = 1'b0;
    dat_in = '0;
    set_cfg(20, 3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_vld", dat_out_vld, 0);
    chk("rst_rdy", dat_in_rdy, 1);
    chk("rst_busy", busy, 0);
    chk("rst_dat", dat_out, 0);
    chk("rst_last", dat_out_last, 0);
`ifdef SOFTMAX_UNPACK_PAD_CHK_EN
    chk("rst_pad_err", pad_err, 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: partial last word, back-to-back, always ready
    rdy_mode = 0;
    pops = 0;
    set_cfg(20, 3);
    send_row(20, 3, 0, 0, 0);
    wait_idle("t1");
    chk("t1_count", pops, 20);
    chk("t1_gap", last_cyc - first_cyc, 19);

    // 2: full last word; input ready while final lane of word 0 leaves
    pops = 0;
    set_cfg(16, 2);
    send_row(16, 2, 0, 0, 0);
    wait_idle("t2");
    chk("t2_count", pops, 16);
    chk("t2_gap", last_cyc - first_cyc, 15);
    chk("t2_reload_rdy", rdy_log[7], 1);

    // 3: single word, alternating backpressure, sequential data
    pops = 0;
    set_cfg(8, 1);
    rdy_mode = 1;
    send_row(8, 1, 1, 0, 0);
    wait_idle("t3");
    chk("t3_count", pops, 8);
    rdy_mode = 0;

    // 4: three-element rows back-to-back
    pops = 0;
    set_cfg(3, 1);
    send_row(3, 1, 0, 0, 0);
    send_row(3, 1, 0, 0, 0);
    wait_idle("t4");
    chk("t4_count", pops, 6);

    // 5: reset after 5 of 8 lanes consumed
    pops = 0;
    set_cfg(8, 1);
    send_row(8, 1, 1, 0, 0);
    for (int t = 0; t < 200; t++) begin
      @(posedge clk);
      if (pops >= 5) break;
    end
    #1;
    rst = 1'b1;
    #1;
    chk("t5_rst_vld", dat_out_vld, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_rdy", dat_in_rdy, 1);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    pops = 0;
    send_row(8, 1, 1, 0, 0);
    wait_idle("t5");
    chk("t5_count", pops, 8);

    // Random configurations, random gaps, random backpressure
    rdy_mode = 2;
    for (int c = 0; c < 10; c++) begin
      ch = $urandom_range(1, 40);
      div = (ch + TOUT - 1) / TOUT;
      rows = $urandom_range(1, 3);
      set_cfg(ch, div);
      for (int r = 0; r < rows; r++) send_row(ch, div, 0, 0, 2);
      wait_idle("rand");
    end
    rdy_mode = 0;

`ifdef SOFTMAX_UNPACK_PAD_CHK_EN
    // 6: nonzero pad lane sets sticky pad_err
    chk("t6_pad_err_clean", pad_err, 0);
    pops = 0;
    pad_arm = 1;
    set_cfg(20, 3);
    send_row(20, 3, 0, 1, 0);
    wait_idle("t6");
    pad_arm = 0;
    chk("t6_pad_err", pad_err, 1);
    send_row(20, 3, 0, 0, 0);
    wait_idle("t6b");
    chk("t6_pad_err_sticky", pad_err, 1);
    rst = 1'b1;
    #1;
    chk("t6_pad_err_rst", pad_err, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
